frogger_level_tracker: RTL and testbench
========================================

// Module: frogger_level_tracker
// PURPOSE
//  Game-progress stage feeding the two-digit 7-segment decoder: owns the current level (1..MAX_LEVEL),
//  remaining lives and the round FSM. Consumes frog events (reached home row, hit by car) and a start
//  button; produces binary o_Level (7 bits, drives the decoder's level input) plus control pulses for
//  the frog/lane logic (respawn, level-up speed change).
// PARAMETERS
//  MAX_LEVEL    99          level saturation value; must be <=99, since the decoder shows two digits
//  START_LIVES  3           lives loaded at game start; range 1..3
//  HOLD_CYCLES  25_000_000  pause length in LEVEL_UP and DEAD states (1 s at 25 MHz)
// PORTS
//  i_Clk         in   1  system clock; all state updates on rising edge
//  i_Rst_n       in   1  asynchronous, active-low reset
//  i_Start       in   1  start button, already debounced; level-sensitive, rising edge used
//  i_Frog_Home   in   1  high while frog occupies goal row; rising edge used
//  i_Frog_Hit    in   1  high while frog overlaps a car; rising edge used
//  o_Level       out  7  current level, binary 0..MAX_LEVEL (0 only in IDLE)
//  o_Lives       out  2  remaining lives
//  o_Playing     out  1  high in PLAY only; gates frog movement and collision checks
//  o_Level_Up    out  1  one-cycle pulse on PLAY->LEVEL_UP
//  o_Respawn     out  1  one-cycle pulse when returning to PLAY; frog returns to start position
//  o_Game_Over   out  1  high in GAME_OVER
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, o_Level=0, o_Lives=0, all 1-bit outputs 0,
//    edge-detect history registers=0, hold counter=0.
//  - Edge detect: each of i_Start/i_Frog_Home/i_Frog_Hit registered once; event = in & ~prev.
//    Event is visible to the FSM the same cycle the input first reads high; 1-cycle response latency.
//  - FSM states: IDLE, PLAY, LEVEL_UP, DEAD, GAME_OVER.
//    IDLE:      start event -> PLAY; o_Level<=1, o_Lives<=START_LIVES, o_Respawn pulse.
//    PLAY:      home event -> LEVEL_UP; o_Level<=o_Level+1 unless already MAX_LEVEL (saturate, no wrap);
//               o_Level_Up pulses even at saturation.
//               hit event (no home event) -> if o_Lives==1: o_Lives<=0, GAME_OVER; else o_Lives-1, DEAD.
//               home and hit on same cycle: home wins, hit ignored.
//    LEVEL_UP/DEAD: hold counter counts 0..HOLD_CYCLES-1; on terminal count -> PLAY, counter<=0,
//               o_Respawn pulse. All frog events ignored (edge history still tracks inputs).
//    GAME_OVER: o_Level and o_Lives frozen for display; start event -> IDLE-equivalent restart,
//               i.e. directly PLAY with level 1, full lives, o_Respawn pulse.
//  - Start event in PLAY/LEVEL_UP/DEAD: ignored.
//  - Input held high across state changes never re-triggers (edge only); input high at reset release
//    is not an event since history resets to 0 -> it IS an event on first sampled cycle; accepted.
//  - Hold counter width = $clog2(HOLD_CYCLES); no other arithmetic wider than 7 bits.
//  - Reset mid-hold or mid-pulse: everything returns to reset values immediately; no pulse completes.
// STRUCTURE
//  - Shared package frogger_pkg: state encoding localparams (IDLE..GAME_OVER), LEVEL_W=7, LIVES_W=2.
//  - One natural sub-module: rise_edge_detect (1-bit, async active-low reset), instanced three times.
//  - FSM, level/lives registers and hold counter stay in this module; outputs registered.
// TESTING (bench uses HOLD_CYCLES=4)
//  1 Reset then start pulse -> next cycle o_Playing=1, o_Level=1, o_Lives=3, o_Respawn high 1 cycle.
//  2 Home pulse in PLAY -> o_Level=2, o_Level_Up 1 cycle, o_Playing=0 for 4 cycles, then o_Respawn, PLAY.
//  3 Three hit pulses separated by holds -> lives 2,1,0; after third o_Game_Over=1, o_Level unchanged;
//    start -> level 1, lives 3, PLAY.
//  4 Home and hit asserted same cycle with lives=1 -> level increments, lives stay 1, no GAME_OVER.
//  5 Force 98 level-ups -> o_Level=99; further home event -> stays 99, o_Level_Up still pulses.
//  6 i_Frog_Hit held high 20 cycles / assert i_Rst_n low mid-DEAD -> one decrement only / all outputs 0 async.

Source files
------------

// File: rtl/frogger_level_tracker_pkg.sv
// Shared types and widths for the Frogger level/lives tracker.
package frogger_level_tracker_pkg;

  localparam int LEVEL_W = 7;
  localparam int LIVES_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_LEVEL_UP  = 3'd2,
    ST_DEAD      = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Level increment that sticks at the display limit instead of wrapping.
  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] level,
                                                 input logic [LEVEL_W-1:0] max_level);
    return (level >= max_level) ? level : level + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/frogger_level_tracker_if.sv
// Event inputs and game-progress outputs of the level tracker.
interface frogger_level_tracker_if;
  import frogger_level_tracker_pkg::*;

  logic               start;
  logic               frog_home;
  logic               frog_hit;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic               playing;
  logic               level_up;
  logic               respawn;
  logic               game_over;

  modport master (
    output start, frog_home, frog_hit,
    input  level, lives, playing, level_up, respawn, game_over
  );

  modport slave (
    input  start, frog_home, frog_hit,
    output level, lives, playing, level_up, respawn, game_over
  );

endinterface

// File: rtl/frogger_level_tracker_rise_edge_detect.sv
// Rising-edge detector; the event is combinational so the FSM sees it on the first high cycle.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/frogger_level_tracker.sv
// Round FSM owning level, lives and the post-event hold; all outputs are registered.
module frogger_level_tracker
  import frogger_level_tracker_pkg::*;
#(
  parameter int MAX_LEVEL   = 99,
  parameter int START_LIVES = 3,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input logic                    clk,
  input logic                    rst_n,
  frogger_level_tracker_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(START_LIVES);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [LEVEL_W-1:0] level_q;
  logic [LIVES_W-1:0] lives_q;
  logic               playing_q;
  logic               level_up_q;
  logic               respawn_q;
  logic               game_over_q;
  logic               start_ev;
  logic               home_ev;
  logic               hit_ev;

  rise_edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .sig(bus.start),     .rise(start_ev));
  rise_edge_detect u_home_edge  (.clk(clk), .rst_n(rst_n), .sig(bus.frog_home), .rise(home_ev));
  rise_edge_detect u_hit_edge   (.clk(clk), .rst_n(rst_n), .sig(bus.frog_hit),  .rise(hit_ev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      level_q     <= '0;
      lives_q     <= '0;
      playing_q   <= 1'b0;
      level_up_q  <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      level_up_q <= 1'b0;
      respawn_q  <= 1'b0;
      case (state)
        // GAME_OVER keeps level/lives on the display until a restart.
        ST_IDLE, ST_GAME_OVER: begin
          if (start_ev) begin
            state       <= ST_PLAY;
            level_q     <= LEVEL_W'(1);
            lives_q     <= LIVES_FULL;
            playing_q   <= 1'b1;
            respawn_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (home_ev) begin
            state      <= ST_LEVEL_UP;
            level_q    <= sat_inc(level_q, LEVEL_MAX);
            level_up_q <= 1'b1;
            playing_q  <= 1'b0;
            hold_cnt   <= '0;
          end else if (hit_ev) begin
            playing_q <= 1'b0;
            hold_cnt  <= '0;
            if (lives_q == LIVES_W'(1)) begin
              state       <= ST_GAME_OVER;
              lives_q     <= '0;
              game_over_q <= 1'b1;
            end else begin
              state   <= ST_DEAD;
              lives_q <= lives_q - LIVES_W'(1);
            end
          end
        end
        ST_LEVEL_UP, ST_DEAD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= ST_PLAY;
            hold_cnt  <= '0;
            playing_q <= 1'b1;
            respawn_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.level     = level_q;
  assign bus.lives     = lives_q;
  assign bus.playing   = playing_q;
  assign bus.level_up  = level_up_q;
  assign bus.respawn   = respawn_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_frogger_level_tracker.sv
// Directed bench for frogger_level_tracker with a 4-cycle hold.
module tb_frogger_level_tracker;
  import frogger_level_tracker_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  frogger_level_tracker_if bus ();

  frogger_level_tracker #(
    .MAX_LEVEL(99),
    .START_LIVES(3),
    .HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.level, bus.lives, bus.playing, bus.level_up, bus.respawn, bus.game_over} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got lvl=%0d lives=%0d pl=%b lu=%b rs=%b go=%b want all 0",
               bus.level, bus.lives, bus.playing, bus.level_up, bus.respawn, bus.game_over);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.playing !== 1'b0 || bus.level !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_start: got pl=%b lvl=%0d want pl=0 lvl=0", bus.playing, bus.level);
    end
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    tick();
    vectors++;
    if (bus.playing !== 1'b1 || bus.level !== 7'd1 || bus.lives !== 2'd3 || bus.respawn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_enter_play: got pl=%b lvl=%0d lives=%0d rs=%b want 1/1/3/1",
               bus.playing, bus.level, bus.lives, bus.respawn);
    end
    bus.start = 1'b0;
    tick();
    vectors++;
    if (bus.respawn !== 1'b0 || bus.playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_respawn_one_cycle: got rs=%b pl=%b want rs=0 pl=1", bus.respawn, bus.playing);
    end
    // Start inside PLAY must not restart the round.
    bus.start = 1'b1;
    tick();
    vectors++;
    if (bus.level !== 7'd1 || bus.lives !== 2'd3 || bus.respawn !== 1'b0 || bus.playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_ignored_in_play: got lvl=%0d lives=%0d rs=%b pl=%b want 1/3/0/1",
               bus.level, bus.lives, bus.respawn, bus.playing);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_level_up();
    bus.frog_home = 1'b1;
    tick();
    vectors++;
    if (bus.level !== 7'd2 || bus.level_up !== 1'b1 || bus.playing !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL level_up_enter: got lvl=%0d lu=%b pl=%b want 2/1/0", bus.level, bus.level_up, bus.playing);
    end
    bus.frog_home = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.frog_hit = (i == 0);
      tick();
      vectors++;
      if (bus.playing !== 1'b0 || bus.level_up !== 1'b0 || bus.lives !== 2'd3) begin
        miscompares++;
        $display("[TB] FAIL level_up_hold: cycle %0d got pl=%b lu=%b lives=%0d want 0/0/3",
                 i, bus.playing, bus.level_up, bus.lives);
      end
    end
    bus.frog_hit = 1'b0;
    tick();
    vectors++;
    if (bus.playing !== 1'b1 || bus.respawn !== 1'b1 || bus.level !== 7'd2) begin
      miscompares++;
      $display("[TB] FAIL level_up_respawn: got pl=%b rs=%b lvl=%0d want 1/1/2", bus.playing, bus.respawn, bus.level);
    end
    tick();
  endtask

  task automatic test_lives_and_game_over();
    logic [1:0] exp_lives;
    for (int k = 0; k < 3; k++) begin
      exp_lives = 2'(2 - k);
      bus.frog_hit = 1'b1;
      tick();
      vectors++;
      if (bus.lives !== exp_lives || bus.game_over !== (k == 2) || bus.playing !== 1'b0 || bus.level !== 7'd2) begin
        miscompares++;
        $display("[TB] FAIL hit_%0d: got lives=%0d go=%b pl=%b lvl=%0d want %0d/%0b/0/2",
                 k, bus.lives, bus.game_over, bus.playing, bus.level, exp_lives, (k == 2));
      end
      bus.frog_hit = 1'b0;
      if (k < 2) begin
        repeat (4) tick();
        vectors++;
        if (bus.playing !== 1'b1 || bus.respawn !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL dead_respawn_%0d: got pl=%b rs=%b want 1/1", k, bus.playing, bus.respawn);
        end
        tick();
      end
    end
    repeat (6) tick();
    vectors++;
    if (bus.game_over !== 1'b1 || bus.level !== 7'd2 || bus.lives !== 2'd0 || bus.playing !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL game_over_frozen: got go=%b lvl=%0d lives=%0d pl=%b want 1/2/0/0",
               bus.game_over, bus.level, bus.lives, bus.playing);
    end
    bus.start = 1'b1;
    tick();
    vectors++;
    if (bus.level !== 7'd1 || bus.lives !== 2'd3 || bus.playing !== 1'b1 || bus.respawn !== 1'b1 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart: got lvl=%0d lives=%0d pl=%b rs=%b go=%b want 1/3/1/1/0",
               bus.level, bus.lives, bus.playing, bus.respawn, bus.game_over);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_home_wins();
    for (int k = 0; k < 2; k++) begin
      bus.frog_hit = 1'b1;
      tick();
      bus.frog_hit = 1'b0;
      repeat (5) tick();
    end
    vectors++;
    if (bus.lives !== 2'd1 || bus.playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL home_wins_setup: got lives=%0d pl=%b want 1/1", bus.lives, bus.playing);
    end
    bus.frog_home = 1'b1;
    bus.frog_hit  = 1'b1;
    tick();
    vectors++;
    if (bus.level !== 7'd2 || bus.lives !== 2'd1 || bus.level_up !== 1'b1 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL home_wins: got lvl=%0d lives=%0d lu=%b go=%b want 2/1/1/0",
               bus.level, bus.lives, bus.level_up, bus.game_over);
    end
    bus.frog_home = 1'b0;
    bus.frog_hit  = 1'b0;
    repeat (4) tick();
    vectors++;
    if (bus.playing !== 1'b1 || bus.respawn !== 1'b1 || bus.lives !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL home_wins_respawn: got pl=%b rs=%b lives=%0d want 1/1/1", bus.playing, bus.respawn, bus.lives);
    end
    tick();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 1; i <= 98; i++) begin
      bus.frog_home = 1'b1;
      tick();
      vectors++;
      if (bus.level !== 7'(i + 1) || bus.level_up !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL level_step_%0d: got lvl=%0d lu=%b want %0d/1", i, bus.level, bus.level_up, i + 1);
      end
      bus.frog_home = 1'b0;
      repeat (4) tick();
    end
    vectors++;
    if (bus.level !== 7'd99 || bus.playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL level_reach_max: got lvl=%0d pl=%b want 99/1", bus.level, bus.playing);
    end
    bus.frog_home = 1'b1;
    tick();
    vectors++;
    if (bus.level !== 7'd99 || bus.level_up !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL level_saturate: got lvl=%0d lu=%b want 99/1", bus.level, bus.level_up);
    end
    bus.frog_home = 1'b0;
    repeat (4) tick();
    vectors++;
    if (bus.playing !== 1'b1 || bus.respawn !== 1'b1 || bus.level !== 7'd99) begin
      miscompares++;
      $display("[TB] FAIL saturate_respawn: got pl=%b rs=%b lvl=%0d want 1/1/99", bus.playing, bus.respawn, bus.level);
    end
    tick();
  endtask

  task automatic test_held_hit();
    bus.frog_hit = 1'b1;
    tick();
    vectors++;
    if (bus.lives !== 2'd2 || bus.playing !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_hit_first: got lives=%0d pl=%b want 2/0", bus.lives, bus.playing);
    end
    repeat (19) tick();
    vectors++;
    if (bus.lives !== 2'd2 || bus.playing !== 1'b1 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_hit_once: got lives=%0d pl=%b go=%b want 2/1/0", bus.lives, bus.playing, bus.game_over);
    end
    bus.frog_hit = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.frog_hit = 1'b1;
    tick();
    vectors++;
    if (bus.lives !== 2'd1 || bus.playing !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_dead: got lives=%0d pl=%b want 1/0", bus.lives, bus.playing);
    end
    bus.frog_hit = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.level, bus.lives, bus.playing, bus.level_up, bus.respawn, bus.game_over} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got lvl=%0d lives=%0d pl=%b lu=%b rs=%b go=%b want all 0",
               bus.level, bus.lives, bus.playing, bus.level_up, bus.respawn, bus.game_over);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    vectors++;
    if (bus.playing !== 1'b0 || bus.respawn !== 1'b0 || bus.level !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_resume: got pl=%b rs=%b lvl=%0d want 0/0/0", bus.playing, bus.respawn, bus.level);
    end
  endtask

  task automatic test_start_held_at_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    tick();
    vectors++;
    if (bus.playing !== 1'b0 || bus.level !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL start_during_reset: got pl=%b lvl=%0d want 0/0", bus.playing, bus.level);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.playing !== 1'b1 || bus.level !== 7'd1 || bus.respawn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_held_release: got pl=%b lvl=%0d rs=%b want 1/1/1", bus.playing, bus.level, bus.respawn);
    end
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.frog_home = 1'b0;
    bus.frog_hit  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_start();
    test_level_up();
    test_lives_and_game_over();
    test_home_wins();
    test_saturation();
    test_held_hit();
    test_async_reset();
    test_start_held_at_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
